// File: rtl/ones_pattern_gen.sv
// Ones-pattern generator: builds an 8-bit word holding a requested number of ones, one bit per cycle.
// Optional ONES_SCATTER_EN rotates each pattern by a per-request rotation counter.
module ones_pattern_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [3:0] req_count,
    output logic       req_ready,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       busy,
    output logic       count_clip
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [2:0] idx_q;
    logic [7:0] byte_q;
    logic       clip_q;

    logic [3:0] cnt_clip_d;
    logic       over_d;
    logic [2:0] pos_d;
    logic       bit_d;

    assign over_d     = (req_count > 4'd8);
    assign cnt_clip_d = over_d ? 4'd8 : req_count;
    assign bit_d      = ({1'b0, idx_q} < cnt_q);

`ifdef ONES_SCATTER_EN
    logic [2:0] rot_q;
    logic [2:0] rot_cap_q;

    // Position wraps naturally in 3 bits, giving the rotate-left by the captured offset.
    assign pos_d = idx_q + rot_cap_q;
`else
    assign pos_d = idx_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= 3'd0;
            byte_q    <= 8'd0;
            clip_q    <= 1'b0;
`ifdef ONES_SCATTER_EN
            rot_q     <= 3'd0;
            rot_cap_q <= 3'd0;
`endif
        end else begin
            clip_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        cnt_q   <= cnt_clip_d;
                        clip_q  <= over_d;
                        byte_q  <= 8'd0;
                        idx_q   <= 3'd0;
                        state_q <= BUILD;
`ifdef ONES_SCATTER_EN
                        rot_cap_q <= rot_q;
                        rot_q     <= rot_q + 3'd1;
`endif
                    end
                end
                BUILD: begin
                    byte_q[pos_d] <= bit_d;
                    idx_q         <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (byte_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign byte_valid = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign byte_out   = byte_q;
    assign count_clip = clip_q;

endmodule
